// File: rtl/modulo_entrada_operador.sv
`default_nettype none
// ---------------------------------------------------------------------------
// modulo_entrada_operador: operator key conditioning and cork entry counter
// with a request/acknowledge hand-off to the stock datapath.  Rev 1.0
// ---------------------------------------------------------------------------
module modulo_entrada_operador #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_ENTRY       = 99
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       n_btn_op,
  input  logic       n_btn_c,
  input  logic       n_btn_load,
  input  logic       load_ack,
  output logic       op_level,
  output logic       op_c_level,
  output logic [6:0] entry_count,
  output logic       load_req,
  output logic       load_op,
  output logic       ovf
);

  localparam int         c_NKEY = 3;
  localparam logic [7:0] c_DB   = 8'(DEBOUNCE_CYCLES);
  localparam logic [6:0] c_MAX  = 7'(MAX_ENTRY);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  // Key index: 0 = operation, 1 = cork count, 2 = load
  logic [c_NKEY-1:0] w_raw;
  logic [c_NKEY-1:0] w_level;
  logic [c_NKEY-1:0] w_press;

  assign w_raw = ~{n_btn_load, n_btn_c, n_btn_op};

  for (genvar g = 0; g < c_NKEY; g++) begin : g_key
    logic       sync1_q, sync2_q, level_q, prev_q;
    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
      if (clr) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        level_q <= 1'b0;
        prev_q  <= 1'b0;
        cnt_q   <= 8'd0;
      end else begin
        sync1_q <= w_raw[g];
        sync2_q <= sync1_q;
        prev_q  <= level_q;
        if (sync2_q == level_q) begin
          cnt_q <= 8'd0;
        end else if (cnt_q + 8'd1 == c_DB) begin
          level_q <= ~level_q;
          cnt_q   <= 8'd0;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end

    assign w_level[g] = level_q;
    assign w_press[g] = level_q & ~prev_q;
  end

  state_t     state_q, state_d;
  logic [6:0] entry_q, entry_d;
  logic       op_q, op_d;
  logic       ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      entry_q <= 7'd0;
      op_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      op_q    <= op_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    op_d    = op_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (w_press[1]) begin
          if (entry_q < c_MAX) entry_d = entry_q + 7'd1;
          else                 ovf_d   = 1'b1;
        end
        // Commit judges the count after any same-cycle increment
        if (w_press[2] && (entry_d != 7'd0)) begin
          op_d    = w_level[0];
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (load_ack) begin
          entry_d = 7'd0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign op_level    = w_level[0];
  assign op_c_level  = w_level[1];
  assign entry_count = entry_q;
  assign load_req    = (state_q == S_REQ);
  assign load_op     = op_q;
  assign ovf         = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_modulo_entrada_operador.sv
`default_nettype none
// Bench for modulo_entrada_operador: directed plan steps plus random key
// sequences checked against an abstract operator-panel model.
module tb_modulo_entrada_operador;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       n_btn_op = 1'b1, n_btn_c = 1'b1, n_btn_load = 1'b1, load_ack = 1'b0;
  logic       op_level, op_c_level, load_req, load_op, ovf;
  logic [6:0] entry_count;

  int total = 0;
  int bad   = 0;

  // Reference model: what the panel should show once keys have settled
  int m_entry, m_ovf, m_req, m_op, m_oplvl;

  modulo_entrada_operador #(.DEBOUNCE_CYCLES(4), .MAX_ENTRY(99)) dut (
    .clk(clk), .clr(clr), .n_btn_op(n_btn_op), .n_btn_c(n_btn_c),
    .n_btn_load(n_btn_load), .load_ack(load_ack), .op_level(op_level),
    .op_c_level(op_c_level), .entry_count(entry_count), .load_req(load_req),
    .load_op(load_op), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".entry"}, int'(entry_count), m_entry);
    chk({tag, ".ovf"},   int'(ovf),         m_ovf);
    chk({tag, ".req"},   int'(load_req),    m_req);
    chk({tag, ".op"},    int'(load_op),     m_op);
    chk({tag, ".oplvl"}, int'(op_level),    m_oplvl);
  endtask

  task automatic do_reset(input int n);
    clr = 1'b1;
    tick(n);
    clr = 1'b0;
    m_entry = 0; m_ovf = 0; m_req = 0; m_op = 0;
    m_oplvl = (n_btn_op == 1'b0) ? 1 : 0;
  endtask

  // Clean press: held long enough to debounce, then released and settled
  task automatic press_count();
    n_btn_c = 1'b0; tick(8);
    n_btn_c = 1'b1; tick(8);
    if (!m_req) begin
      if (m_entry < 99) m_entry++;
      else              m_ovf = 1;
    end
  endtask

  task automatic press_load();
    n_btn_load = 1'b0; tick(8);
    n_btn_load = 1'b1; tick(8);
    if (!m_req && m_entry > 0) begin
      m_req = 1;
      m_op  = m_oplvl;
    end
  endtask

  task automatic press_both();
    n_btn_c = 1'b0; n_btn_load = 1'b0; tick(8);
    n_btn_c = 1'b1; n_btn_load = 1'b1; tick(8);
    if (!m_req) begin
      if (m_entry < 99) m_entry++;
      else              m_ovf = 1;
      if (m_entry > 0) begin
        m_req = 1;
        m_op  = m_oplvl;
      end
    end
  endtask

  task automatic set_op(input int pressed);
    n_btn_op = (pressed != 0) ? 1'b0 : 1'b1;
    tick(8);
    m_oplvl = (pressed != 0) ? 1 : 0;
  endtask

  task automatic pulse_ack();
    load_ack = 1'b1; tick(1);
    load_ack = 1'b0;
    if (m_req) begin
      m_req = 0; m_entry = 0; m_ovf = 0;
    end
  endtask

  initial begin
    int act;
    m_entry = 0; m_ovf = 0; m_req = 0; m_op = 0; m_oplvl = 0;

    // Reset and glitch rejection
    do_reset(2);
    chk_all("reset");
    chk("reset.oclvl", int'(op_c_level), 0);
    n_btn_c = 1'b0; tick(3);
    n_btn_c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("glitch.oclvl", int'(op_c_level), 0);
      tick(1);
    end
    chk("glitch.entry", int'(entry_count), 0);

    // Debounce latency: first sample at edge k, level at k+5, count at k+6
    n_btn_c = 1'b0;
    tick(5);
    chk("lat.oclvl_early", int'(op_c_level), 0);
    tick(1);
    chk("lat.oclvl", int'(op_c_level), 1);
    chk("lat.entry_early", int'(entry_count), 0);
    tick(1);
    chk("lat.entry", int'(entry_count), 1);
    tick(3);
    n_btn_c = 1'b1; tick(8);
    m_entry = 1;
    chk("held.oclvl", int'(op_c_level), 0);
    chk_all("held");

    // Count and commit with remove selected
    do_reset(1);
    for (int i = 0; i < 7; i++) press_count();
    set_op(1);
    press_load();
    chk_all("commit");
    set_op(0);
    press_count();
    press_load();
    chk_all("frozen");
    chk("pre_ack.req", int'(load_req), 1);
    load_ack = 1'b1; tick(1); load_ack = 1'b0;
    m_req = 0; m_entry = 0; m_ovf = 0;
    chk_all("ack_edge");
    tick(4);
    chk_all("ack_after");

    // Saturation and ovf clear on acknowledge
    for (int i = 0; i < 101; i++) press_count();
    chk_all("sat");
    press_load();
    chk_all("sat_req");
    pulse_ack();
    tick(1);
    chk_all("sat_ack");

    // Empty commit, then stray ack in IDLE
    press_load();
    chk_all("empty");
    press_count();
    press_count();
    pulse_ack();
    tick(2);
    chk_all("stray_ack");

    // Simultaneous count and load at entry 3
    press_count();
    press_both();
    chk_all("simul");
    pulse_ack();
    tick(1);

    // Reset while requesting
    for (int i = 0; i < 12; i++) press_count();
    press_load();
    chk_all("mid_req");
    do_reset(1);
    chk_all("mid_rst");
    chk("mid_rst.oclvl", int'(op_c_level), 0);
    press_count();
    chk_all("post_rst");

    // Random operator sequences
    for (int i = 0; i < 60; i++) begin
      act = $urandom_range(0, 9);
      if (act <= 3)      press_count();
      else if (act <= 5) press_load();
      else if (act <= 7) pulse_ack();
      else if (act == 8) set_op(m_oplvl == 0 ? 1 : 0);
      else               press_both();
      tick(1);
      chk_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/modulo_entrada_operador.md
# modulo_entrada_operador

Operator front-end for the bottling plant's cork-stock path: conditions the raw active-low board keys and accumulates the operator's cork entry count. It hands that count to the stock datapath through a request/acknowledge transfer. It is the producing end of the signals the cork-stock logic consumes: debounced operator levels, the cork-entry count and the add/remove operation. It runs on the divided system clock.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required before a debounced level changes (range 2..255).
- MAX_ENTRY, default 99: saturation value of the entry count (must be ≤ 127).

Ports:
- clk  in  1  system clock (divided clock).
- clr  in  1  reset, synchronous, active-high.
- n_btn_op  in  1  raw operator key, active-low. Pressed = add/remove select (1 = remove).
- n_btn_c  in  1  raw cork-count key, active-low. Each press adds one cork.
- n_btn_load  in  1  raw commit key, active-low.
- load_ack  in  1  datapath acknowledge of the pending transfer.
- op_level  out  1  debounced operator key, 1 = pressed.
- op_c_level  out  1  debounced cork-count key, 1 = pressed.
- entry_count  out  7  accumulated corks, 0..MAX_ENTRY.
- load_req  out  1  transfer request, held until acknowledged.
- load_op  out  1  operation captured at commit: 0 = add, 1 = remove.
- ovf  out  1  sticky flag: a count press occurred while entry_count = MAX_ENTRY.

## Operation
- Input path, per key: invert to active-high, then apply a 2-FF synchronizer, then the debounce counter. The synchronizer resets to 0 (not pressed).
- Debounce rule: the counter clears whenever the synchronized value equals the debounced level. Otherwise it increments. When it reaches DEBOUNCE_CYCLES, the level toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never reach the outputs.
- Press detection: a registered copy of each debounced level is kept. A press pulse is defined as level=1 while the copy is 0, and lasts one cycle.
- The load key is debounced internally and is not exported.
- FSM states:
  - IDLE:
    - Count press with entry_count < MAX_ENTRY: entry_count += 1.
    - Count press with entry_count = MAX_ENTRY: count holds, ovf ← 1.
    - Load press with entry_count > 0 (value after any same-cycle increment): load_op ← op_level, go to REQ.
    - Load press with entry_count = 0: ignored.
  - REQ:
    - load_req = 1. entry_count and load_op are frozen.
    - Count presses and load presses are ignored and not queued.
    - load_ack = 1: entry_count ← 0, ovf ← 0, go to IDLE.
- load_ack in IDLE is ignored.
- op_level changes during REQ do not alter load_op.
- Arithmetic: entry_count is 7-bit unsigned, saturating at MAX_ENTRY, and never wraps.

## Timing
- Reset: clr sampled high clears everything on that edge: synchronizers, debounce counters, levels, press copies, entry_count = 0, load_req = 0, load_op = 0, ovf = 0, FSM = IDLE.
  - clr during REQ drops the request with no acknowledge required.
- Debounce latency: a raw key change held stable is first sampled at edge k. The debounced level changes on edge k+1+DEBOUNCE_CYCLES, i.e. it is visible DEBOUNCE_CYCLES+1 cycles later.
- entry_count updates on the edge after op_c_level rises (1-cycle latency).
- load_req rises on the edge after the internal load level rises.
- Handshake:
  - load_ack is sampled each edge while in REQ.
  - load_req falls and entry_count clears on the same edge that samples load_ack = 1.
  - Minimum REQ duration is 1 cycle.
  - load_ack already high on entry to REQ is accepted on the following edge.
- Simultaneous count press and load press in IDLE: the increment applies first, and REQ carries the incremented count.
- Key held down: exactly one press event per press, with no auto-repeat.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and MAX_ENTRY=99.
- Reset/debounce: assert clr 2 cycles, then pulse n_btn_c low for 3 cycles → op_c_level stays 0 and entry_count = 0. Hold it low 10 cycles → op_c_level = 1 at 5 cycles after the first sample, and entry_count = 1 one cycle later.
- Count and commit: 7 clean count presses, then n_btn_op held low, then a load press → load_req = 1, entry_count = 7, load_op = 1. Release n_btn_op and press count → values unchanged. Assert load_ack 1 cycle → load_req = 0, entry_count = 0 on the same edge.
- Saturation: 101 count presses → entry_count = 99, ovf = 1. Commit and acknowledge → ovf = 0.
- Empty commit and stray ack: load press with entry_count = 0 → load_req stays 0. load_ack pulses in IDLE → no state change.
- Simultaneous: count press and load press on the same cycle with entry_count = 3 → load_req = 1 with entry_count = 4.
- Reset mid-request: in REQ with entry_count = 12, assert clr 1 cycle → all outputs 0, FSM IDLE, next count press gives entry_count = 1.
